// File: rtl/wb_cache_pkg.sv
// Shared types and constants for the LC-3b line cache.
package wb_cache_pkg;

  localparam int unsigned LC3B_LINE_BYTES = 16;

  // Sized for the default 8-set configuration with a 16-bit byte address
  typedef logic [8:0] lc3b_c_tag;
  typedef logic [2:0] lc3b_c_index;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    FILL
  } wb_cache_state_t;

endpackage

// File: rtl/wb_cache_if.sv
// 128-bit line-wide Wishbone bus shared by the pipeline and memory sides.
interface wishbone;
  import wb_cache_pkg::*;

  logic [15:0]                    ADR;
  logic [LC3B_LINE_BYTES*8-1:0]   DAT_M;
  logic [LC3B_LINE_BYTES*8-1:0]   DAT_S;
  logic [LC3B_LINE_BYTES-1:0]     SEL;
  logic                           CYC;
  logic                           STB;
  logic                           WE;
  logic                           ACK;

  modport master (output ADR, DAT_M, SEL, CYC, STB, WE, input DAT_S, ACK);
  modport slave  (input ADR, DAT_M, SEL, CYC, STB, WE, output DAT_S, ACK);
endinterface

// File: rtl/wb_cache_array.sv
// Per-set storage: asynchronous read, synchronous load, optional async clear.
module cache_array #(
  parameter int unsigned width    = 1,
  parameter int unsigned num_sets = 8
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic                        load,
  input  logic [$clog2(num_sets)-1:0] index,
  input  logic [width-1:0]            din,
  output logic [width-1:0]            dout
);

  logic [width-1:0] mem [num_sets];

  // Data and tag instances tie clr_n high, so only valid/dirty ever clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < num_sets; i++) mem[i] <= '0;
    end else if (load) begin
      mem[index] <= din;
    end
  end

  assign dout = mem[index];

endmodule

// File: rtl/wb_cache.sv
// Direct-mapped write-back line cache: Wishbone responder to the pipeline,
// Wishbone master toward physical memory for victim writeback and line fill.
module wb_cache
  import wb_cache_pkg::*;
#(
  parameter int unsigned num_sets = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  wishbone.slave  cpu,
  wishbone.master mem
);

  localparam int unsigned IW = $clog2(num_sets);
  localparam int unsigned TW = 12 - IW;
  localparam int unsigned LW = LC3B_LINE_BYTES * 8;

  wb_cache_state_t state, next_state;

  logic [15:4]                req_adr;
  logic                       req_we;
  logic [LC3B_LINE_BYTES-1:0] req_sel;
  logic [LW-1:0]              req_dat;

  logic [IW-1:0] idx;
  logic [TW-1:0] req_tag;

  logic [LW-1:0] data_q, data_d, merged;
  logic [TW-1:0] tag_q;
  logic          valid_q, dirty_q, dirty_d;
  logic          data_load, tag_load, valid_load, dirty_load;
  logic          hit;

  assign idx     = req_adr[IW+3:4];
  assign req_tag = req_adr[15:IW+4];
  assign hit     = valid_q && (tag_q == req_tag);

  cache_array #(.width(LW), .num_sets(num_sets)) u_data (
    .clk(clk), .clr_n(1'b1), .load(data_load), .index(idx), .din(data_d), .dout(data_q)
  );
  cache_array #(.width(TW), .num_sets(num_sets)) u_tag (
    .clk(clk), .clr_n(1'b1), .load(tag_load), .index(idx), .din(req_tag), .dout(tag_q)
  );
  cache_array #(.width(1), .num_sets(num_sets)) u_valid (
    .clk(clk), .clr_n(rst_n), .load(valid_load), .index(idx), .din(1'b1), .dout(valid_q)
  );
  cache_array #(.width(1), .num_sets(num_sets)) u_dirty (
    .clk(clk), .clr_n(rst_n), .load(dirty_load), .index(idx), .din(dirty_d), .dout(dirty_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_adr <= '0;
      req_we  <= 1'b0;
      req_sel <= '0;
      req_dat <= '0;
    end else if (state == IDLE && cpu.CYC && cpu.STB) begin
      req_adr <= cpu.ADR[15:4];
      req_we  <= cpu.WE;
      req_sel <= cpu.SEL;
      req_dat <= cpu.DAT_M;
    end
  end

  always_comb begin
    merged = data_q;
    for (int unsigned i = 0; i < LC3B_LINE_BYTES; i++) begin
      if (req_sel[i]) merged[i*8 +: 8] = req_dat[i*8 +: 8];
    end
  end

  assign cpu.DAT_S = data_q;

  always_comb begin
    next_state = state;
    cpu.ACK    = 1'b0;
    mem.CYC    = 1'b0;
    mem.STB    = 1'b0;
    mem.WE     = 1'b0;
    mem.ADR    = '0;
    mem.SEL    = '0;
    mem.DAT_M  = '0;
    data_load  = 1'b0;
    data_d     = merged;
    tag_load   = 1'b0;
    valid_load = 1'b0;
    dirty_load = 1'b0;
    dirty_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu.CYC && cpu.STB) next_state = CHECK;
      end
      CHECK: begin
        if (hit) begin
          cpu.ACK    = 1'b1;
          next_state = IDLE;
          if (req_we) begin
            data_load  = 1'b1;
            dirty_load = 1'b1;
            dirty_d    = 1'b1;
          end
        end else if (valid_q && dirty_q) begin
          next_state = WRITEBACK;
        end else begin
          next_state = FILL;
        end
      end
      WRITEBACK: begin
        mem.CYC   = 1'b1;
        mem.STB   = 1'b1;
        mem.WE    = 1'b1;
        mem.ADR   = {tag_q, idx, 4'b0};
        mem.SEL   = '1;
        mem.DAT_M = data_q;
        if (mem.ACK) begin
          dirty_load = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        mem.CYC = 1'b1;
        mem.STB = 1'b1;
        mem.ADR = {req_tag, idx, 4'b0};
        mem.SEL = '1;
        // Whole line lands at once; the request is re-evaluated in CHECK
        if (mem.ACK) begin
          data_load  = 1'b1;
          data_d     = mem.DAT_S;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          next_state = CHECK;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cache.sv
// Self-checking bench for wb_cache: directed scenarios plus random traffic
// checked against an architectural memory/cache reference model.
module tb_wb_cache;
  import wb_cache_pkg::*;

  typedef struct {
    bit           we;
    logic [15:0]  adr;
    logic [127:0] data;
    logic [15:0]  sel;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wishbone cpu_bus ();
  wishbone mem_bus ();

  wb_cache #(.num_sets(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cpu_bus), .mem(mem_bus)
  );

  int errors = 0;
  int checks = 0;
  int mem_k  = 3;
  int resp_cnt = 0;

  logic [127:0] mem_store [4096];
  logic [127:0] truth     [4096];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [8:0]   m_tag   [8];
  txn_t         txq[$];
  txn_t         exp_q[$];

  // Memory responder: ACK in the k-th cycle that STB is high
  always @(negedge clk) begin
    mem_bus.ACK = 1'b0;
    if (rst_n && mem_bus.CYC && mem_bus.STB) begin
      resp_cnt++;
      if (resp_cnt >= mem_k) begin
        resp_cnt = 0;
        mem_bus.ACK = 1'b1;
        txq.push_back(txn_t'{mem_bus.WE, mem_bus.ADR, mem_bus.DAT_M, mem_bus.SEL});
        if (mem_bus.WE) mem_store[mem_bus.ADR[15:4]] = mem_bus.DAT_M;
        else            mem_bus.DAT_S = mem_store[mem_bus.ADR[15:4]];
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic model_reset;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    for (int i = 0; i < 4096; i++) truth[i] = mem_store[i];
  endtask

  task automatic model_access(input logic [15:0] adr, input bit we, input logic [15:0] sel,
                              input logic [127:0] dat, output int exp_lat,
                              output logic [127:0] exp_rd);
    logic [11:0] line, vline;
    logic [2:0]  s;
    line = adr[15:4];
    s    = line[2:0];
    exp_q.delete();
    if (m_valid[s] && m_tag[s] == line[11:3]) begin
      exp_lat = 1;
    end else begin
      if (m_valid[s] && m_dirty[s]) begin
        vline = {m_tag[s], s};
        exp_q.push_back(txn_t'{1'b1, {vline, 4'h0}, truth[vline], 16'hFFFF});
        exp_lat = 2 * mem_k + 2;
      end else begin
        exp_lat = mem_k + 2;
      end
      exp_q.push_back(txn_t'{1'b0, {line, 4'h0}, 128'h0, 16'hFFFF});
      m_valid[s] = 1;
      m_tag[s]   = line[11:3];
      m_dirty[s] = 0;
    end
    if (we) begin
      for (int b = 0; b < 16; b++)
        if (sel[b]) truth[line][b*8 +: 8] = dat[b*8 +: 8];
      m_dirty[s] = 1;
    end
    exp_rd = truth[line];
  endtask

  // Called aligned 1 time unit after a rising edge; cycle 0 is the request cycle
  task automatic cpu_access(input logic [15:0] adr, input bit we, input logic [15:0] sel,
                            input logic [127:0] dat, output logic [127:0] rdata,
                            output int lat);
    cpu_bus.ADR   = adr;
    cpu_bus.WE    = we;
    cpu_bus.SEL   = sel;
    cpu_bus.DAT_M = dat;
    cpu_bus.CYC   = 1'b1;
    cpu_bus.STB   = 1'b1;
    lat   = -1;
    rdata = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cpu_bus.ACK) begin
        lat   = c;
        rdata = cpu_bus.DAT_S;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cpu_bus.CYC = 1'b0;
    cpu_bus.STB = 1'b0;
    cpu_bus.WE  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({cpu_bus.ACK, mem_bus.CYC, mem_bus.STB, mem_bus.WE} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack/cyc/stb/we=%b required 0000",
               {cpu_bus.ACK, mem_bus.CYC, mem_bus.STB, mem_bus.WE});
    end
    checks++;
    if (mem_bus.ADR !== 16'h0 || mem_bus.SEL !== 16'h0) begin
      errors++;
      $display("FAIL reset_adr_sel: adr=%h sel=%h required 0/0", mem_bus.ADR, mem_bus.SEL);
    end
    checks++;
    if (mem_bus.DAT_M !== 128'h0) begin
      errors++;
      $display("FAIL reset_dat_m: got %h required 0", mem_bus.DAT_M);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss;
    logic [127:0] rd, ed;
    int lat, el;
    mem_k = 3;
    txq.delete();
    model_access(16'h0040, 0, 16'h0, 128'h0, el, ed);
    cpu_access(16'h0040, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL miss_latency: got %0d required 5", lat);
    end
    checks++;
    if (rd !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL miss_data: got %h required %h", rd, {16{8'hA5}});
    end
    checks++;
    if (txq.size() != 1 || txq[0].we !== 1'b0 || txq[0].adr !== 16'h0040) begin
      errors++;
      $display("FAIL miss_mem_txn: count=%0d required one read at 0040", txq.size());
    end
  endtask

  task automatic test_read_hit;
    logic [127:0] rd, ed;
    int lat, el;
    txq.delete();
    model_access(16'h0048, 0, 16'h0, 128'h0, el, ed);
    cpu_access(16'h0048, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL hit_latency: got %0d required 1", lat);
    end
    checks++;
    if (rd !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL hit_data: got %h required %h", rd, {16{8'hA5}});
    end
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL hit_no_mem: got %0d memory transactions required 0", txq.size());
    end
  endtask

  task automatic test_write_hit;
    logic [127:0] rd, ed, want;
    int lat, el;
    want = {16{8'hA5}};
    want[31:16] = 16'hBEEF;
    txq.delete();
    model_access(16'h0042, 1, 16'h000C, 128'hBEEF << 16, el, ed);
    cpu_access(16'h0042, 1, 16'h000C, 128'hBEEF << 16, rd, lat);
    checks++;
    if (lat !== 1 || txq.size() != 0) begin
      errors++;
      $display("FAIL write_hit: latency=%0d mem_txns=%0d required 1/0", lat, txq.size());
    end
    model_access(16'h0040, 0, 16'h0, 128'h0, el, ed);
    cpu_access(16'h0040, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (rd !== want) begin
      errors++;
      $display("FAIL write_merge_read: got %h required %h", rd, want);
    end
  endtask

  task automatic test_dirty_evict;
    logic [127:0] rd, ed, want;
    int lat, el;
    want = {16{8'hA5}};
    want[31:16] = 16'hBEEF;
    mem_k = 2;
    txq.delete();
    model_access(16'h0440, 0, 16'h0, 128'h0, el, ed);
    cpu_access(16'h0440, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (txq.size() != 2) begin
      errors++;
      $display("FAIL evict_txn_count: got %0d required 2", txq.size());
    end else begin
      checks++;
      if (txq[0].we !== 1'b1 || txq[0].adr !== 16'h0040 || txq[0].sel !== 16'hFFFF ||
          txq[0].data !== want) begin
        errors++;
        $display("FAIL evict_writeback: we=%b adr=%h sel=%h data=%h required 1/0040/ffff/%h",
                 txq[0].we, txq[0].adr, txq[0].sel, txq[0].data, want);
      end
      checks++;
      if (txq[1].we !== 1'b0 || txq[1].adr !== 16'h0440) begin
        errors++;
        $display("FAIL evict_fill: we=%b adr=%h required 0/0440", txq[1].we, txq[1].adr);
      end
    end
    checks++;
    if (lat !== 6 || rd !== ed) begin
      errors++;
      $display("FAIL evict_ack: latency=%0d data=%h required 6/%h", lat, rd, ed);
    end
  endtask

  task automatic test_write_miss;
    logic [127:0] rd, ed, line_after;
    int lat, el;
    mem_k = 1;
    txq.delete();
    model_access(16'h0050, 1, 16'h0001, 128'h3C, el, ed);
    cpu_access(16'h0050, 1, 16'h0001, 128'h3C, rd, lat);
    checks++;
    if (lat !== 3 || txq.size() != 1 || (txq.size() == 1 && txq[0].we !== 1'b0)) begin
      errors++;
      $display("FAIL write_miss_fill: latency=%0d mem_txns=%0d required 3/1 read", lat, txq.size());
    end
    model_access(16'h0050, 0, 16'h0, 128'h0, el, line_after);
    cpu_access(16'h0050, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (rd !== line_after || rd[7:0] !== 8'h3C) begin
      errors++;
      $display("FAIL write_miss_merge: got %h required %h", rd, line_after);
    end
    txq.delete();
    model_access(16'h0450, 0, 16'h0, 128'h0, el, ed);
    cpu_access(16'h0450, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (txq.size() != 2 || txq[0].we !== 1'b1 || txq[0].adr !== 16'h0050 ||
        txq[0].data !== line_after) begin
      errors++;
      $display("FAIL write_miss_dirty: mem_txns=%0d required writeback of 0050 with %h",
               txq.size(), line_after);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [127:0] rd, ed;
    int lat, el;
    bit seen;
    mem_k = 8;
    seen = 0;
    cpu_bus.ADR = 16'h0040;
    cpu_bus.WE  = 1'b0;
    cpu_bus.SEL = 16'h0;
    cpu_bus.CYC = 1'b1;
    cpu_bus.STB = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_bus.STB && !mem_bus.WE) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midfill_start: fill never started within 20 cycles");
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_bus.CYC !== 1'b0 || cpu_bus.ACK !== 1'b0) begin
      errors++;
      $display("FAIL midfill_abort: cyc=%b ack=%b required 0/0", mem_bus.CYC, cpu_bus.ACK);
    end
    cpu_bus.CYC = 1'b0;
    cpu_bus.STB = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_k = 3;
    txq.delete();
    model_access(16'h0040, 0, 16'h0, 128'h0, el, ed);
    cpu_access(16'h0040, 0, 16'h0, 128'h0, rd, lat);
    checks++;
    if (lat !== 5 || txq.size() != 1 || rd !== ed) begin
      errors++;
      $display("FAIL midfill_remiss: latency=%0d mem_txns=%0d data=%h required 5/1/%h",
               lat, txq.size(), rd, ed);
    end
  endtask

  task automatic test_random;
    logic [127:0] rd, ed, dat;
    logic [15:0]  adr, sel;
    bit  we;
    int  lat, el;
    for (int n = 0; n < 60; n++) begin
      mem_k = $urandom_range(1, 4);
      adr = {7'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom)};
      we  = 1'($urandom);
      sel = 16'($urandom);
      dat = {$urandom, $urandom, $urandom, $urandom};
      txq.delete();
      model_access(adr, we, sel, dat, el, ed);
      cpu_access(adr, we, sel, dat, rd, lat);
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL rand_latency[%0d]: adr=%h got %0d required %0d", n, adr, lat, el);
      end
      if (!we) begin
        checks++;
        if (rd !== ed) begin
          errors++;
          $display("FAIL rand_data[%0d]: adr=%h got %h required %h", n, adr, rd, ed);
        end
      end
      checks++;
      if (txq.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_txn_count[%0d]: got %0d required %0d", n, txq.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (txq[i].we !== exp_q[i].we || txq[i].adr !== exp_q[i].adr ||
              txq[i].sel !== 16'hFFFF || (exp_q[i].we && txq[i].data !== exp_q[i].data)) begin
            errors++;
            $display("FAIL rand_txn[%0d.%0d]: we=%b adr=%h got data %h required we=%b adr=%h data %h",
                     n, i, txq[i].we, txq[i].adr, txq[i].data,
                     exp_q[i].we, exp_q[i].adr, exp_q[i].data);
          end
        end
      end
    end
  endtask

  initial begin
    cpu_bus.ADR   = '0;
    cpu_bus.DAT_M = '0;
    cpu_bus.SEL   = '0;
    cpu_bus.CYC   = 1'b0;
    cpu_bus.STB   = 1'b0;
    cpu_bus.WE    = 1'b0;
    for (int i = 0; i < 4096; i++)
      mem_store[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_store[12'h004] = {16{8'hA5}};
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
